// File: rtl/sorter_pkg.sv
// Shared types and helpers for the parametrised weight sorter family.
// FSM state encoding, reset-time default thresholds and width helpers
// used by weight_sorter_n and sorter_classify.
package sorter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    // Default threshold i: 250,500,750,1500,2000 then +500 per further step.
    function automatic int def_thr(input int i);
        int t;
        case (i)
            0:       t = 250;
            1:       t = 500;
            2:       t = 750;
            3:       t = 1500;
            4:       t = 2000;
            default: t = 2000 + 500 * (i - 4);
        endcase
        return t;
    endfunction

    // Width of a bin number 0..n_grp (0 meaning no item).
    function automatic int grp_w(input int n_grp);
        return $clog2(n_grp + 1);
    endfunction

    // Width of a threshold index 0..n_grp-2; never narrower than one bit.
    function automatic int idx_w(input int n_grp);
        return (n_grp > 2) ? $clog2(n_grp - 1) : 1;
    endfunction

endpackage

// File: rtl/sorter_classify.sv
// Combinational priority comparator: maps a weight onto a bin number.
// Bin g (1..N_GRP-1) is chosen for the lowest g with weight <= thr[g-1];
// anything above every threshold lands in bin N_GRP. The lowest matching
// index always wins, so non-monotonic threshold tables are well defined.
module sorter_classify
    import sorter_pkg::*;
#(
    parameter int W     = 12,
    parameter int N_GRP = 6
) (
    input  logic [W-1:0]                weight,
    input  logic [N_GRP-2:0][W-1:0]     thr,
    output logic [grp_w(N_GRP)-1:0]     bin
);

    localparam int GRP_W = grp_w(N_GRP);

    // Scan from the highest threshold down so the lowest match overwrites last.
    always_comb begin
        bin = GRP_W'(N_GRP);
        for (int g = N_GRP - 2; g >= 0; g--) begin
            if (weight <= thr[g]) begin
                bin = GRP_W'(g + 1);
            end
        end
    end

endmodule

// File: rtl/weight_sorter_n.sv
// Parametrised weight sorter: settles each item on the scale, classifies it
// against run-time programmable thresholds and counts it when it leaves.
// Optional reject path enabled by defining WEIGHT_SORTER_REJECT_EN: items
// heavier than MAX_WEIGHT show all-ones on current_grp and are tallied in
// reject_count instead of a bin counter and total_count.
module weight_sorter_n
    import sorter_pkg::*;
#(
    parameter int W          = 12,
    parameter int N_GRP      = 6,
    parameter int CNT_W      = 8,
    parameter int SETTLE_CYC = 2,
    parameter int MAX_WEIGHT = 4000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [W-1:0]              weight,
    input  logic                      thr_wr_en,
    input  logic [idx_w(N_GRP)-1:0]   thr_wr_idx,
    input  logic [W-1:0]              thr_wr_data,
    output logic [N_GRP*CNT_W-1:0]    grp_count,
    output logic [grp_w(N_GRP)-1:0]   current_grp,
    output logic                      item_done,
    output logic [15:0]               total_count
`ifdef WEIGHT_SORTER_REJECT_EN
    ,
    output logic [CNT_W-1:0]          reject_count
`endif
);

    localparam int          GRP_W       = grp_w(N_GRP);
    localparam int          IDX_W       = idx_w(N_GRP);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [W-1:0]              sample;
    logic [3:0]                stable_cnt;
    logic                      stable_last;
    logic [N_GRP-2:0][W-1:0]   thr;
    logic [GRP_W-1:0]          bin;
    logic [GRP_W-1:0]          held_bin;
    logic [CNT_W-1:0]          cnt [N_GRP];
    logic                      do_latch;
    logic                      do_stable;
    logic                      do_hold;
    logic                      do_count;
    logic                      count_bin;

`ifdef WEIGHT_SORTER_REJECT_EN
    logic                      is_reject;
    logic                      held_reject;

    assign is_reject = (weight > W'(MAX_WEIGHT));
    assign count_bin = do_count && !held_reject;
`else
    assign count_bin = do_count;
`endif

    // The next stable sample completes the settle window.
    assign stable_last = ((stable_cnt + 4'd1) >= SETTLE_LAST);

    sorter_classify #(
        .W     (W),
        .N_GRP (N_GRP)
    ) u_classify (
        .weight (weight),
        .thr    (thr),
        .bin    (bin)
    );

    // Threshold table: defaults on reset, single-entry writes otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_GRP - 1; i++) begin
                thr[i] <= W'(def_thr(i));
            end
        end else if (thr_wr_en) begin
            for (int i = 0; i < N_GRP - 1; i++) begin
                if (thr_wr_idx == IDX_W'(i)) begin
                    thr[i] <= thr_wr_data;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (weight != '0) begin
                    state_nxt = (SETTLE_CYC == 1) ? HELD : SETTLE;
                end
            end
            SETTLE: begin
                if (weight == '0) begin
                    state_nxt = IDLE;
                end else if ((weight == sample) && stable_last) begin
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (weight == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM control strobes for the settle, hold and count datapath.
    always_comb begin
        do_latch  = 1'b0;
        do_stable = 1'b0;
        do_hold   = 1'b0;
        do_count  = 1'b0;
        case (state)
            IDLE: begin
                if (weight != '0) begin
                    if (SETTLE_CYC == 1) begin
                        do_hold = 1'b1;
                    end else begin
                        do_latch = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (weight != '0) begin
                    if (weight != sample) begin
                        do_latch = 1'b1;
                    end else if (stable_last) begin
                        do_hold = 1'b1;
                    end else begin
                        do_stable = 1'b1;
                    end
                end
            end
            HELD: begin
                if (weight == '0) begin
                    do_count = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Settle filter: latched sample and count of consecutive matching cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample     <= '0;
            stable_cnt <= '0;
        end else if (do_latch) begin
            sample     <= weight;
            stable_cnt <= '0;
        end else if (do_stable) begin
            stable_cnt <= stable_cnt + 4'd1;
        end
    end

    // Bin capture on entering HELD, cleared with a done pulse on exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            current_grp <= '0;
            held_bin    <= '0;
            item_done   <= 1'b0;
`ifdef WEIGHT_SORTER_REJECT_EN
            held_reject <= 1'b0;
`endif
        end else begin
            item_done <= do_count;
            if (do_hold) begin
                held_bin <= bin;
`ifdef WEIGHT_SORTER_REJECT_EN
                held_reject <= is_reject;
                current_grp <= is_reject ? '1 : bin;
`else
                current_grp <= bin;
`endif
            end else if (do_count) begin
                current_grp <= '0;
            end
        end
    end

    // Saturating per-bin counters and total, bumped as an item leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int g = 0; g < N_GRP; g++) begin
                cnt[g] <= '0;
            end
            total_count <= '0;
        end else if (count_bin) begin
            for (int g = 0; g < N_GRP; g++) begin
                if ((held_bin == GRP_W'(g + 1)) && (cnt[g] != '1)) begin
                    cnt[g] <= cnt[g] + CNT_W'(1);
                end
            end
            if (total_count != 16'hFFFF) begin
                total_count <= total_count + 16'd1;
            end
        end
    end

`ifdef WEIGHT_SORTER_REJECT_EN
    // Saturating tally of rejected items.
    always_ff @(posedge clk) begin
        if (reset) begin
            reject_count <= '0;
        end else if (do_count && held_reject && (reject_count != '1)) begin
            reject_count <= reject_count + CNT_W'(1);
        end
    end
`endif

    genvar gi;
    for (gi = 0; gi < N_GRP; gi++) begin : g_flat
        assign grp_count[gi*CNT_W +: CNT_W] = cnt[gi];
    end

endmodule

// File: tb/tb_weight_sorter_n.sv
// Directed bench for weight_sorter_n. A second instance with 2-bit counters
// shares the stimulus and exercises counter saturation.
`timescale 1ns/1ps
module tb_weight_sorter_n;

    localparam int W     = 12;
    localparam int N_GRP = 6;
    localparam int CNT_W = 8;
    localparam int SAT_W = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [W-1:0]           weight;
    logic                   thr_wr_en;
    logic [2:0]             thr_wr_idx;
    logic [W-1:0]           thr_wr_data;

    logic [N_GRP*CNT_W-1:0] grp_count;
    logic [2:0]             current_grp;
    logic                   item_done;
    logic [15:0]            total_count;

    logic [N_GRP*SAT_W-1:0] grp_count_s;
    logic [2:0]             current_grp_s;
    logic                   item_done_s;
    logic [15:0]            total_count_s;

`ifdef WEIGHT_SORTER_REJECT_EN
    logic [CNT_W-1:0]       reject_count;
    logic [SAT_W-1:0]       reject_count_s;
`endif

    int total_checks = 0;
    int bad_checks   = 0;
    int done_pulses  = 0;
    int done_pulses_s = 0;
    int pulse_base;
    int pulse_base_s;

    weight_sorter_n #(
        .W(W), .N_GRP(N_GRP), .CNT_W(CNT_W), .SETTLE_CYC(2), .MAX_WEIGHT(4000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .weight      (weight),
        .thr_wr_en   (thr_wr_en),
        .thr_wr_idx  (thr_wr_idx),
        .thr_wr_data (thr_wr_data),
        .grp_count   (grp_count),
        .current_grp (current_grp),
        .item_done   (item_done),
        .total_count (total_count)
`ifdef WEIGHT_SORTER_REJECT_EN
        ,
        .reject_count(reject_count)
`endif
    );

    weight_sorter_n #(
        .W(W), .N_GRP(N_GRP), .CNT_W(SAT_W), .SETTLE_CYC(2), .MAX_WEIGHT(4000)
    ) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .weight      (weight),
        .thr_wr_en   (thr_wr_en),
        .thr_wr_idx  (thr_wr_idx),
        .thr_wr_data (thr_wr_data),
        .grp_count   (grp_count_s),
        .current_grp (current_grp_s),
        .item_done   (item_done_s),
        .total_count (total_count_s)
`ifdef WEIGHT_SORTER_REJECT_EN
        ,
        .reject_count(reject_count_s)
`endif
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Tally item_done pulses mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (item_done === 1'b1) done_pulses++;
        if (item_done_s === 1'b1) done_pulses_s++;
    end

    function automatic logic [31:0] binCount(input int g);
        return 32'(grp_count[(g-1)*CNT_W +: CNT_W]);
    endfunction

    function automatic logic [31:0] binCountSat(input int g);
        return 32'(grp_count_s[(g-1)*SAT_W +: SAT_W]);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_checks++;
        assert (observed === expected)
        else begin
            bad_checks++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset       = 1'b1;
        weight      = '0;
        thr_wr_en   = 1'b0;
        thr_wr_idx  = '0;
        thr_wr_data = '0;
        tick(2);
        reset = 1'b0;
    endtask

    // Present one item for 20 cycles, check its bin while held, then a 20-cycle gap.
    task automatic applyStimulus(input logic [W-1:0] w, input int exp_bin);
        weight = w;
        tick(20);
        checkOutput($sformatf("held_grp_w%0d", w), 32'(current_grp), exp_bin);
        weight = '0;
        tick(20);
    endtask

    initial begin
        $display("[TB] weight_sorter_n directed run");
        doReset();

        // Reset state.
        checkOutput("rst_grp_count", 32'(grp_count), 0);
        checkOutput("rst_total", 32'(total_count), 0);
        checkOutput("rst_current_grp", 32'(current_grp), 0);
        checkOutput("rst_item_done", 32'(item_done), 0);

        // First item with explicit latency checks.
        pulse_base = done_pulses;
        weight = 12'd16;
        tick(1);
        checkOutput("lat_settling_grp", 32'(current_grp), 0);
        tick(1);
        checkOutput("lat_held_grp", 32'(current_grp), 1);
        tick(18);
        weight = '0;
        tick(1);
        checkOutput("exit_item_done", 32'(item_done), 1);
        checkOutput("exit_bin1", binCount(1), 1);
        checkOutput("exit_grp_clear", 32'(current_grp), 0);
        tick(1);
        checkOutput("exit_done_drop", 32'(item_done), 0);
        tick(18);

        applyStimulus(12'd501, 3);
        applyStimulus(12'd600, 3);
        applyStimulus(12'd1600, 5);
        applyStimulus(12'd2005, 6);
        checkOutput("set1_bin1", binCount(1), 1);
        checkOutput("set1_bin2", binCount(2), 0);
        checkOutput("set1_bin3", binCount(3), 2);
        checkOutput("set1_bin4", binCount(4), 0);
        checkOutput("set1_bin5", binCount(5), 1);
        checkOutput("set1_bin6", binCount(6), 1);
        checkOutput("set1_total", 32'(total_count), 5);
        checkOutput("set1_pulses", 32'(done_pulses - pulse_base), 5);

        // Boundary values land in the lower bin.
        doReset();
        applyStimulus(12'd750, 3);
        applyStimulus(12'd751, 4);
        applyStimulus(12'd1500, 4);
        applyStimulus(12'd1501, 5);
        applyStimulus(12'd1506, 5);
        checkOutput("set2_bin1", binCount(1), 0);
        checkOutput("set2_bin2", binCount(2), 0);
        checkOutput("set2_bin3", binCount(3), 1);
        checkOutput("set2_bin4", binCount(4), 2);
        checkOutput("set2_bin5", binCount(5), 2);
        checkOutput("set2_bin6", binCount(6), 0);

        // Glitch filter: a single-cycle item is dropped.
        doReset();
        weight = 12'd300;
        tick(1);
        weight = '0;
        checkOutput("glitch_grp_settle", 32'(current_grp), 0);
        tick(5);
        checkOutput("glitch_total", 32'(total_count), 0);
        checkOutput("glitch_grp_after", 32'(current_grp), 0);

        // Alternating zero/nonzero never settles.
        for (int i = 0; i < 10; i++) begin
            weight = 12'd300;
            tick(1);
            weight = '0;
            tick(1);
        end
        checkOutput("alt_total", 32'(total_count), 0);

        // A changing weight re-latches; only the final stable value counts.
        weight = 12'd300;
        tick(1);
        weight = 12'd900;
        tick(1);
        checkOutput("relatch_grp", 32'(current_grp), 0);
        tick(1);
        checkOutput("relatch_held", 32'(current_grp), 4);
        tick(10);
        weight = '0;
        tick(5);
        checkOutput("relatch_bin2", binCount(2), 0);
        checkOutput("relatch_bin4", binCount(4), 1);
        checkOutput("relatch_total", 32'(total_count), 1);

        // Threshold write in the classifying cycle uses the old value.
        doReset();
        weight = 12'd150;
        tick(1);
        thr_wr_en   = 1'b1;
        thr_wr_idx  = 3'd0;
        thr_wr_data = 12'd100;
        tick(1);
        thr_wr_en = 1'b0;
        checkOutput("thr_same_cycle_grp", 32'(current_grp), 1);
        tick(5);
        checkOutput("thr_held_keeps", 32'(current_grp), 1);
        weight = '0;
        tick(3);
        checkOutput("thr_old_bin1", binCount(1), 1);

        // Out-of-range index is ignored; new T[0]=100 sends 150 to bin 2.
        thr_wr_en   = 1'b1;
        thr_wr_idx  = 3'd5;
        thr_wr_data = 12'd1;
        tick(1);
        thr_wr_en = 1'b0;
        applyStimulus(12'd150, 2);
        applyStimulus(12'd2005, 6);
        checkOutput("thr_new_bin2", binCount(2), 1);
        checkOutput("thr_new_bin6", binCount(6), 1);

        // Saturation: five bin-1 items on 8-bit and 2-bit counter instances.
        doReset();
        pulse_base_s = done_pulses_s;
        for (int i = 0; i < 5; i++) begin
            weight = 12'd10;
            tick(5);
            weight = '0;
            tick(3);
        end
        checkOutput("sat_wide_bin1", binCount(1), 5);
        checkOutput("sat_narrow_bin1", binCountSat(1), 3);
        checkOutput("sat_narrow_total", 32'(total_count_s), 5);
        checkOutput("sat_narrow_bin2", binCountSat(2), 0);
        checkOutput("sat_narrow_pulses", 32'(done_pulses_s - pulse_base_s), 5);

        // Reset while HELD discards the item and gives no pulse.
        pulse_base = done_pulses;
        weight = 12'd10;
        tick(2);
        checkOutput("rsthold_grp", 32'(current_grp), 1);
        checkOutput("rsthold_grp_narrow", 32'(current_grp_s), 1);
        reset = 1'b1;
        tick(1);
        checkOutput("rsthold_grp_zero", 32'(current_grp), 0);
        checkOutput("rsthold_counts_zero", 32'(grp_count), 0);
        checkOutput("rsthold_total_zero", 32'(total_count), 0);
        tick(1);
        checkOutput("rsthold_no_pulse", 32'(done_pulses - pulse_base), 0);
        reset = 1'b0;
        tick(1);
        checkOutput("rsthold_resettle", 32'(current_grp), 0);
        tick(1);
        checkOutput("rsthold_reheld", 32'(current_grp), 1);
        weight = '0;
        tick(2);
        checkOutput("rsthold_recount", binCount(1), 1);
        checkOutput("rsthold_one_pulse", 32'(done_pulses - pulse_base), 1);

        // Overweight item.
        doReset();
        pulse_base = done_pulses;
`ifdef WEIGHT_SORTER_REJECT_EN
        weight = 12'd4095;
        tick(10);
        checkOutput("reject_grp_ones", 32'(current_grp), 7);
        weight = '0;
        tick(3);
        checkOutput("reject_count", 32'(reject_count), 1);
        checkOutput("reject_bin6", binCount(6), 0);
        checkOutput("reject_total", 32'(total_count), 0);
        checkOutput("reject_narrow", 32'(reject_count_s), 1);
`else
        applyStimulus(12'd4095, 6);
        checkOutput("heavy_bin6", binCount(6), 1);
        checkOutput("heavy_total", 32'(total_count), 1);
`endif
        checkOutput("heavy_pulse", 32'(done_pulses - pulse_base), 1);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
